// File: rtl/lcd_line_buffer.sv
// lcd_line_buffer: assembles two-byte PPU pixels into RGB555, stores them in a
// pair of 160-pixel line banks and replays each completed line to a
// downstream display over a valid/ready pixel stream.
//
// Output handshake: pix_valid qualifies pix_rgb/pix_x/pix_y/pix_sof/pix_eol.
// Once pix_valid is high, every pix_* output holds its value until a cycle in
// which pix_ready is also high; that rising edge is the transfer.
module lcd_line_buffer (
  input  logic        clk_ppu,
  input  logic        reset_n,
  input  logic        lcd_enable,
  input  logic        v_blank_int_sig,
  input  logic        color_pixel_good,
  input  logic [7:0]  color_pixel,
  input  logic        pix_ready,
  output logic        pix_valid,
  output logic [14:0] pix_rgb,
  output logic [7:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        overflow_err
);

  typedef enum logic [1:0] {PH_LOW, PH_HIGH, PH_SKIP} phase_e;
  typedef enum logic [1:0] {BK_FREE, BK_FILLING, BK_FULL, BK_DRAINING} bank_e;
  typedef enum logic [1:0] {RD_IDLE, RD_LOAD, RD_SEND} rd_e;

  localparam logic [7:0] LAST_X = 8'd159;
  localparam logic [7:0] LAST_Y = 8'd143;

  phase_e      phase_q, phase_d;
  logic [7:0]  low_q, low_d;
  bank_e       bank_q [2];
  bank_e       bank_d [2];
  logic [7:0]  tag_q [2];
  logic [7:0]  tag_d [2];
  logic        wr_bank_q, wr_bank_d;
  logic [7:0]  wr_x_q, wr_x_d;
  logic [7:0]  wr_y_q, wr_y_d;
  logic        ovf_q, ovf_d;
  rd_e         rd_state_q, rd_state_d;
  logic        rd_bank_q, rd_bank_d;
  logic        valid_q, valid_d;
  logic [7:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [14:0] rgb_q, rgb_d;

  logic [14:0] line_mem [2][160];
  logic        wr_req;
  logic        wr_en;
  logic [14:0] wr_rgb;
  logic        rd_other;
  logic [7:0]  rd_next_x;

  assign rd_other  = ~rd_bank_q;
  assign rd_next_x = x_q + 8'd1;
  assign wr_rgb    = {color_pixel[6:0], low_q};

  // Next-state logic: byte assembly, write side, frame discard, read side, enable flush.
  always_comb begin
    phase_d    = phase_q;
    low_d      = low_q;
    bank_d     = bank_q;
    tag_d      = tag_q;
    wr_bank_d  = wr_bank_q;
    wr_x_d     = wr_x_q;
    wr_y_d     = wr_y_q;
    ovf_d      = ovf_q;
    rd_state_d = rd_state_q;
    rd_bank_d  = rd_bank_q;
    valid_d    = valid_q;
    x_d        = x_q;
    y_d        = y_q;
    rgb_d      = rgb_q;
    wr_req     = 1'b0;
    wr_en      = 1'b0;

    // A strobe run gives low byte then high byte; anything after is ignored.
    if (color_pixel_good) begin
      case (phase_q)
        PH_LOW:  begin low_d = color_pixel; phase_d = PH_HIGH; end
        PH_HIGH: begin wr_req = 1'b1; phase_d = PH_SKIP; end
        default: phase_d = PH_SKIP;
      endcase
    end else begin
      phase_d = PH_LOW;
    end

    // The write side only ever touches a bank that is FREE or FILLING, the
    // read side only FULL or DRAINING, so both may update bank_d in one cycle.
    if (wr_req) begin
      if (bank_q[wr_bank_q] == BK_FREE || bank_q[wr_bank_q] == BK_FILLING) begin
        wr_en = 1'b1;
        if (wr_x_q == LAST_X) begin
          bank_d[wr_bank_q] = BK_FULL;
          tag_d[wr_bank_q]  = wr_y_q;
          wr_bank_d         = ~wr_bank_q;
          wr_x_d            = 8'd0;
          wr_y_d            = (wr_y_q == LAST_Y) ? 8'd0 : wr_y_q + 8'd1;
        end else begin
          bank_d[wr_bank_q] = BK_FILLING;
          wr_x_d            = wr_x_q + 8'd1;
        end
      end else begin
        ovf_d = 1'b1;
      end
    end

    // Frame end throws away a partly written line; completed lines survive.
    if (v_blank_int_sig) begin
      if (bank_d[wr_bank_d] == BK_FILLING) bank_d[wr_bank_d] = BK_FREE;
      wr_x_d = 8'd0;
      wr_y_d = 8'd0;
    end

    case (rd_state_q)
      RD_IDLE: begin
        if (bank_q[rd_bank_q] == BK_FULL) begin
          bank_d[rd_bank_q] = BK_DRAINING;
          rd_state_d        = RD_LOAD;
        end
      end
      RD_LOAD: begin
        rgb_d      = line_mem[rd_bank_q][0];
        x_d        = 8'd0;
        y_d        = tag_q[rd_bank_q];
        valid_d    = 1'b1;
        rd_state_d = RD_SEND;
      end
      RD_SEND: begin
        if (pix_ready) begin
          if (x_q == LAST_X) begin
            bank_d[rd_bank_q] = BK_FREE;
            rd_bank_d         = rd_other;
            if (bank_q[rd_other] == BK_FULL) begin
              // Next line is already complete: continue without a gap.
              bank_d[rd_other] = BK_DRAINING;
              rgb_d            = line_mem[rd_other][0];
              x_d              = 8'd0;
              y_d              = tag_q[rd_other];
            end else begin
              valid_d    = 1'b0;
              rd_state_d = RD_IDLE;
            end
          end else begin
            rgb_d = line_mem[rd_bank_q][rd_next_x];
            x_d   = rd_next_x;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase

    // Display off: flush everything and ignore the pixel stream.
    if (!lcd_enable) begin
      phase_d    = PH_LOW;
      bank_d[0]  = BK_FREE;
      bank_d[1]  = BK_FREE;
      wr_bank_d  = 1'b0;
      wr_x_d     = 8'd0;
      wr_y_d     = 8'd0;
      ovf_d      = 1'b0;
      rd_state_d = RD_IDLE;
      rd_bank_d  = 1'b0;
      valid_d    = 1'b0;
      x_d        = 8'd0;
      y_d        = 8'd0;
      rgb_d      = 15'd0;
      wr_en      = 1'b0;
    end
  end

  // Control and output registers with asynchronous reset.
  always_ff @(posedge clk_ppu or negedge reset_n) begin
    if (!reset_n) begin
      phase_q    <= PH_LOW;
      low_q      <= 8'd0;
      bank_q[0]  <= BK_FREE;
      bank_q[1]  <= BK_FREE;
      tag_q[0]   <= 8'd0;
      tag_q[1]   <= 8'd0;
      wr_bank_q  <= 1'b0;
      wr_x_q     <= 8'd0;
      wr_y_q     <= 8'd0;
      ovf_q      <= 1'b0;
      rd_state_q <= RD_IDLE;
      rd_bank_q  <= 1'b0;
      valid_q    <= 1'b0;
      x_q        <= 8'd0;
      y_q        <= 8'd0;
      rgb_q      <= 15'd0;
    end else begin
      phase_q    <= phase_d;
      low_q      <= low_d;
      bank_q     <= bank_d;
      tag_q      <= tag_d;
      wr_bank_q  <= wr_bank_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      ovf_q      <= ovf_d;
      rd_state_q <= rd_state_d;
      rd_bank_q  <= rd_bank_d;
      valid_q    <= valid_d;
      x_q        <= x_d;
      y_q        <= y_d;
      rgb_q      <= rgb_d;
    end
  end

  // Line storage: written on the edge that captures the high byte, never reset.
  always_ff @(posedge clk_ppu) begin
    if (wr_en) line_mem[wr_bank_q][wr_x_q] <= wr_rgb;
  end

  assign pix_valid    = valid_q;
  assign pix_rgb      = rgb_q;
  assign pix_x        = x_q;
  assign pix_y        = y_q;
  assign pix_sof      = valid_q && (x_q == 8'd0) && (y_q == 8'd0);
  assign pix_eol      = valid_q && (x_q == LAST_X);
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_lcd_line_buffer.sv
// Directed bench for lcd_line_buffer: fills lines through the two-byte pixel
// interface and checks every replayed pixel against hand-derived values.
module tb_lcd_line_buffer;

  logic        clk_ppu = 1'b0;
  logic        reset_n;
  logic        lcd_enable;
  logic        v_blank_int_sig;
  logic        color_pixel_good;
  logic [7:0]  color_pixel;
  logic        pix_ready;
  logic        pix_valid;
  logic [14:0] pix_rgb;
  logic [7:0]  pix_x;
  logic [7:0]  pix_y;
  logic        pix_sof;
  logic        pix_eol;
  logic        overflow_err;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Clock
  always #5 clk_ppu = ~clk_ppu;

  lcd_line_buffer dut (
    .clk_ppu          (clk_ppu),
    .reset_n          (reset_n),
    .lcd_enable       (lcd_enable),
    .v_blank_int_sig  (v_blank_int_sig),
    .color_pixel_good (color_pixel_good),
    .color_pixel      (color_pixel),
    .pix_ready        (pix_ready),
    .pix_valid        (pix_valid),
    .pix_rgb          (pix_rgb),
    .pix_x            (pix_x),
    .pix_y            (pix_y),
    .pix_sof          (pix_sof),
    .pix_eol          (pix_eol),
    .overflow_err     (overflow_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] out_bundle();
    return {pix_valid, pix_x, pix_y, pix_rgb, pix_sof, pix_eol};
  endfunction

  // One pixel: low byte cycle, high byte cycle, one idle cycle.
  task automatic send_pixel(input logic [7:0] lo, input logic [7:0] hi);
    @(negedge clk_ppu); color_pixel_good = 1'b1; color_pixel = lo;
    @(negedge clk_ppu); color_pixel = hi;
    @(negedge clk_ppu); color_pixel_good = 1'b0;
  endtask

  // Pixels first_x..159 with low byte = x and a fixed high byte.
  task automatic send_line(input logic [7:0] hi, input int first_x);
    for (int x = first_x; x < 160; x++) send_pixel(x[7:0], hi);
  endtask

  task automatic restart();
    @(negedge clk_ppu); lcd_enable = 1'b0;
    @(negedge clk_ppu); lcd_enable = 1'b1;
  endtask

  // Consume n transfers. mode 0: ready held high (also checks for bubbles);
  // mode 1: ready toggles every cycle (also checks outputs hold during stalls).
  task automatic collect(input logic [7:0] exp_y, input logic [7:0] hi,
                         input logic [14:0] rgb0, input int mode, input int n);
    int k = 0;
    int cyc = 0;
    int bubbles = 0;
    logic started = 1'b0;
    logic stalled = 1'b0;
    logic r;
    logic [33:0] saved = '0;
    logic [14:0] exp_rgb;
    logic [7:0] kx;
    while (k < n && cyc < 3000) begin
      @(negedge clk_ppu);
      cyc++;
      if (stalled) chk("stall_hold", {30'd0, out_bundle()}, {30'd0, saved});
      if (pix_valid) started = 1'b1;
      else if (started && mode == 0) bubbles++;
      r = (mode == 0) ? 1'b1 : cyc[0];
      pix_ready = r;
      if (pix_valid && r) begin
        kx = k[7:0];
        exp_rgb = (k == 0) ? rgb0 : {hi[6:0], kx};
        chk($sformatf("pix_y%0d_x%0d", exp_y, k), {30'd0, out_bundle()},
            {30'd0, 1'b1, kx, exp_y, exp_rgb, (k == 0 && exp_y == 8'd0), (k == 159)});
        k++;
      end
      stalled = pix_valid && !r;
      if (stalled) saved = out_bundle();
    end
    chk("transfer_count", k, n);
    if (mode == 0) chk("bubbles", bubbles, 0);
  endtask

  initial begin
    int vcnt;
    reset_n = 1'b0; lcd_enable = 1'b1; v_blank_int_sig = 1'b0;
    color_pixel_good = 1'b0; color_pixel = 8'h00; pix_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk_ppu);
    chk("reset_outputs", {30'd0, out_bundle()}, 64'd0);
    chk("reset_overflow", overflow_err, 1'b0);
    reset_n = 1'b1;

    // One line with ready high: rgb = 0x0100 | x, y = 0
    send_line(8'h81, 0);
    collect(8'd0, 8'h81, 15'h0100, 0, 160);
    repeat (2) @(negedge clk_ppu);
    chk("idle_after_line", pix_valid, 1'b0);
    chk("no_overflow", overflow_err, 1'b0);

    // Stalled output: both banks fill, 321st pixel overflows
    restart();
    pix_ready = 1'b0;
    send_line(8'h10, 0);
    send_line(8'h22, 0);
    send_pixel(8'h55, 8'h7f);
    @(negedge clk_ppu);
    chk("overflow_set", overflow_err, 1'b1);
    chk("stall_first_pixel", {30'd0, out_bundle()},
        {30'd0, 1'b1, 8'd0, 8'd0, 15'h1000, 1'b1, 1'b0});
    collect(8'd0, 8'h10, 15'h1000, 0, 160);
    collect(8'd1, 8'h22, 15'h2200, 0, 160);
    chk("overflow_sticky", overflow_err, 1'b1);

    // Ready toggling every cycle
    restart();
    chk("overflow_cleared", overflow_err, 1'b0);
    send_line(8'h33, 0);
    collect(8'd0, 8'h33, 15'h3300, 1, 160);

    // Partial line then frame end: no output, next line tagged y = 0
    pix_ready = 1'b1;
    for (int x = 0; x < 80; x++) send_pixel(x[7:0], 8'h44);
    @(negedge clk_ppu); v_blank_int_sig = 1'b1;
    @(negedge clk_ppu); v_blank_int_sig = 1'b0;
    vcnt = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk_ppu);
      if (pix_valid) vcnt++;
    end
    chk("vblank_no_output", vcnt, 0);
    send_line(8'h55, 0);
    collect(8'd0, 8'h55, 15'h5500, 0, 160);

    // 1-cycle strobe ignored; 3-cycle strobe gives one pixel {0x83[6:0], 0x12}
    @(negedge clk_ppu); color_pixel_good = 1'b1; color_pixel = 8'haa;
    @(negedge clk_ppu); color_pixel_good = 1'b0;
    @(negedge clk_ppu); color_pixel_good = 1'b1; color_pixel = 8'h12;
    @(negedge clk_ppu); color_pixel = 8'h83;
    @(negedge clk_ppu); color_pixel = 8'h99;
    @(negedge clk_ppu); color_pixel_good = 1'b0;
    send_line(8'h66, 1);
    collect(8'd1, 8'h66, 15'h0312, 0, 160);

    // Reset mid-drain at x = 50
    restart();
    send_line(8'h77, 0);
    collect(8'd0, 8'h77, 15'h7700, 0, 50);
    @(negedge clk_ppu);
    chk("pre_reset_x", {pix_valid, pix_x}, {1'b1, 8'd50});
    reset_n = 1'b0;
    #1;
    chk("reset_valid_immediate", pix_valid, 1'b0);
    chk("reset_overflow_mid", overflow_err, 1'b0);
    @(negedge clk_ppu); reset_n = 1'b1;
    send_line(8'h08, 0);
    collect(8'd0, 8'h08, 15'h0800, 0, 160);

    // Display disable mid-drain at x = 50
    send_line(8'h09, 0);
    collect(8'd1, 8'h09, 15'h0900, 0, 50);
    @(negedge clk_ppu);
    chk("pre_disable_x", {pix_valid, pix_x}, {1'b1, 8'd50});
    lcd_enable = 1'b0;
    @(negedge clk_ppu);
    chk("disable_valid_next_edge", pix_valid, 1'b0);
    chk("disable_overflow", overflow_err, 1'b0);
    lcd_enable = 1'b1;
    send_line(8'h0a, 0);
    collect(8'd0, 8'h0a, 15'h0a00, 0, 160);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lcd_line_buffer.md
LCD_LINE_BUFFER -- requirements
Module: lcd_line_buffer

Interface
REQ-001 SHALL have port clk_ppu  input  1  single clock, rising edge; same clock that drives the PPU pixel stream.
REQ-002 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port lcd_enable  input  1  LCDC[7]; low means flush and idle.
REQ-004 SHALL have port v_blank_int_sig  input  1  one-cycle frame-end strobe from the PPU.
REQ-005 SHALL have port color_pixel_good  input  1  PPU pixel strobe.
REQ-006 SHALL have port color_pixel  input  8  PPU palette byte.
REQ-007 SHALL have port pix_ready  input  1  downstream display accepts a pixel.
REQ-008 SHALL have port pix_valid  output  1  pix_rgb, pix_x, pix_y, pix_sof and pix_eol are valid.
REQ-009 SHALL have port pix_rgb  output  15  RGB555 colour.
REQ-010 SHALL have ports pix_x  output  8  column 0..159, and pix_y  output  8  line 0..143.
REQ-011 SHALL have ports pix_sof  output  1  pix_x=0 and pix_y=0, and pix_eol  output  1  pix_x=159.
REQ-012 SHALL have port overflow_err  output  1  sticky flag: pixel dropped.

Function
REQ-013 SHALL treat each run of color_pixel_good=1 as one pixel: 1st cycle = low byte, 2nd cycle = high byte; the phase returns to low whenever color_pixel_good=0.
REQ-014 SHALL assemble rgb = {high[6:0], low[7:0]}; high[7] is ignored; a run of length 1 produces no pixel; cycles beyond the 2nd in a run are ignored.
REQ-015 SHALL hold two 160x15 line banks; each bank is in one of FREE, FILLING, FULL or DRAINING.
REQ-016 SHALL write each assembled pixel to wr_bank[wr_x] on the edge that captures the high byte, then increment wr_x.
REQ-017 SHALL handle a write with wr_x=159 as follows: mark the bank FULL tagged with wr_y, toggle wr_bank, set wr_x to 0, and increment wr_y, wrapping 143 to 0.
REQ-018 SHALL drop a pixel whose target bank is not FREE/FILLING, set overflow_err, and leave wr_x unchanged.
REQ-019 SHALL respond to v_blank_int_sig by discarding any partial line (bank back to FREE), setting wr_x to 0 and wr_y to 0; a FULL or DRAINING bank is unaffected.
REQ-020 SHALL, on the first edge after a bank becomes FULL while the read side is idle, mark that bank DRAINING; pix_valid rises on the next edge with pix_x=0.
REQ-021 SHALL follow the valid/ready rule: while pix_valid=1 and pix_ready=0, all pix_* outputs are held stable; a transfer occurs when both are 1.
REQ-022 SHALL sustain one pixel per clock while pix_ready is held at 1, with no bubbles inside a line.
REQ-023 SHALL, after the transfer with pix_x=159, set the bank FREE and move rd_bank to the other bank; pix_valid drops unless that bank is already FULL, in which case it continues back-to-back.
REQ-024 SHALL serve banks strictly alternately, starting with bank 0.
REQ-025 SHALL drive pix_y with the tag latched at FULL, not the live wr_y.
REQ-026 SHALL process a simultaneous write-FULL and read-done on the same edge in one cycle, without loss.
REQ-027 SHALL, while lcd_enable=0, synchronously force the state to: both banks FREE, wr_x=wr_y=0, phase=low, rd_bank=wr_bank=0, pix_valid=0, overflow_err=0, and ignore inputs.

Reset
REQ-028 SHALL, under reset_n=0, asynchronously set all outputs to 0, both banks FREE, and all counters, bank pointers and phase to 0; buffer contents are not reset.

Verification
REQ-029 SHALL pass: with pix_ready=1, one line of 160 pixels where low=x and high=0x81 -> 160 transfers, pix_rgb=0x0100|x, pix_y=0, pix_sof only at x=0, pix_eol only at x=159.
REQ-030 SHALL pass: with pix_ready=0 after line 0 is full, a further 160 pixels fill bank 1 and a 321st pixel sets overflow_err=1; after ready, lines y=0 then y=1 drain intact.
REQ-031 SHALL pass: pix_ready toggling 1/0 every cycle -> no pixel duplicated or lost, outputs stable during stalls.
REQ-032 SHALL pass: 80 pixels then v_blank_int_sig -> no output; the next full line appears with pix_y=0.
REQ-033 SHALL pass: a single-cycle good pulse and a 3-cycle good pulse -> the first is ignored, the second yields one pixel from its first two bytes.
REQ-034 SHALL pass: reset_n or lcd_enable=0 asserted mid-drain at x=50 -> pix_valid=0 immediately (reset) or next edge (enable), overflow_err=0; the next line restarts at bank 0, pix_y=0.
